// File: rtl/sequenciador_envase_if.sv
// Bundles the bottling-line sensor, actuator and status signals between the
// sequencer (slave) and its environment (master).
interface sequenciador_envase_if;
   logic       start;
   logic       stop;
   logic       pos_fill;
   logic       level;
   logic       pos_seal;
   logic       seal_done;
   logic       seal_alarm;
   logic       cork_reload;
   logic       ack;
   logic       motor;
   logic       valve;
   logic       seal_req;
   logic       cork_ok;
   logic [4:0] corks;
   logic [3:0] units;
   logic [6:0] dozens;
   logic       alarm;
   logic [1:0] alarm_code;
   logic       busy;

   modport slave (
      input  start, stop, pos_fill, level, pos_seal, seal_done, seal_alarm,
             cork_reload, ack,
      output motor, valve, seal_req, cork_ok, corks, units, dozens, alarm,
             alarm_code, busy
   );

   modport master (
      output start, stop, pos_fill, level, pos_seal, seal_done, seal_alarm,
             cork_reload, ack,
      input  motor, valve, seal_req, cork_ok, corks, units, dozens, alarm,
             alarm_code, busy
   );
endinterface

// File: rtl/sequenciador_envase.sv
// Bottling-line sequencer: conveyor/fill/seal Moore FSM with cork stock,
// unit/dozen bottle counters and coded line alarm.
module sequenciador_envase #(
   parameter int FILL_TIMEOUT = 15,
   parameter int CORK_MAX     = 20,
   parameter int CORK_LOAD    = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   sequenciador_envase_if.slave  bus
);
   localparam int TW = $clog2(FILL_TIMEOUT) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MOVE_FILL = 3'd1;
   localparam logic [2:0] S_FILL      = 3'd2;
   localparam logic [2:0] S_MOVE_SEAL = 3'd3;
   localparam logic [2:0] S_SEAL      = 3'd4;
   localparam logic [2:0] S_ALARM     = 3'd5;

   localparam logic [1:0] C_NONE    = 2'b00;
   localparam logic [1:0] C_NOCORK  = 2'b01;
   localparam logic [1:0] C_TIMEOUT = 2'b10;
   localparam logic [1:0] C_SEAL    = 2'b11;

   logic [2:0]    r_state;
   logic          r_run;
   logic [TW-1:0] r_fillTimer;
   logic [4:0]    r_corks;
   logic [3:0]    r_units;
   logic [6:0]    r_dozens;
   logic [1:0]    r_code;

   logic [2:0]    w_nextState;
   logic [1:0]    w_nextCode;
   logic          w_sealOk;
   logic [6:0]    w_corksSum;
   logic [4:0]    w_corksNext;

   // A completed seal consumes one cork; reload adds a batch, clipped at capacity.
   assign w_sealOk    = (r_state == S_SEAL) && !bus.seal_alarm && bus.seal_done;
   assign w_corksSum  = {2'b00, r_corks} - {6'd0, w_sealOk}
                        + (bus.cork_reload ? 7'(CORK_LOAD) : 7'd0);
   assign w_corksNext = (w_corksSum > 7'(CORK_MAX)) ? 5'(CORK_MAX) : w_corksSum[4:0];

   always_comb begin
      w_nextState = r_state;
      w_nextCode  = r_code;
      case (r_state)
         S_IDLE: begin
            if (!bus.stop && bus.start) begin
               if (r_corks == 5'd0) begin
                  w_nextState = S_ALARM;
                  w_nextCode  = C_NOCORK;
               end else begin
                  w_nextState = S_MOVE_FILL;
               end
            end
         end
         S_MOVE_FILL: begin
            if (!r_run || bus.stop)
               w_nextState = S_IDLE;
            else if (bus.pos_fill)
               w_nextState = S_FILL;
         end
         S_FILL: begin
            if (bus.level) begin
               w_nextState = S_MOVE_SEAL;
            end else if (r_fillTimer == TW'(FILL_TIMEOUT - 1)) begin
               w_nextState = S_ALARM;
               w_nextCode  = C_TIMEOUT;
            end
         end
         S_MOVE_SEAL: begin
            if (bus.pos_seal)
               w_nextState = S_SEAL;
         end
         S_SEAL: begin
            if (bus.seal_alarm) begin
               w_nextState = S_ALARM;
               w_nextCode  = C_SEAL;
            end else if (bus.seal_done) begin
               w_nextState = (r_run && !bus.stop && (w_corksNext != 5'd0))
                             ? S_MOVE_FILL : S_IDLE;
            end
         end
         S_ALARM: begin
            if (bus.ack && ((r_code != C_NOCORK) || (r_corks != 5'd0))) begin
               w_nextState = S_IDLE;
               w_nextCode  = C_NONE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextCode  = C_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_code      <= C_NONE;
         r_run       <= 1'b0;
         r_fillTimer <= '0;
         r_corks     <= 5'd0;
      end else begin
         r_state <= w_nextState;
         r_code  <= w_nextCode;
         r_corks <= w_corksNext;
         // Entry to IDLE/ALARM clears run first; stop beats the set on leaving IDLE.
         if ((w_nextState == S_IDLE) || (w_nextState == S_ALARM))
            r_run <= 1'b0;
         else if (bus.stop)
            r_run <= 1'b0;
         else if (r_state == S_IDLE)
            r_run <= 1'b1;
         r_fillTimer <= (r_state == S_FILL) ? r_fillTimer + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_units  <= 4'd0;
         r_dozens <= 7'd0;
      end else if (w_sealOk) begin
         if (r_units == 4'd11) begin
            r_units  <= 4'd0;
            r_dozens <= (r_dozens == 7'd99) ? 7'd0 : r_dozens + 7'd1;
         end else begin
            r_units <= r_units + 4'd1;
         end
      end
   end

   assign bus.motor      = (r_state == S_MOVE_FILL) || (r_state == S_MOVE_SEAL);
   assign bus.valve      = (r_state == S_FILL);
   assign bus.seal_req   = (r_state == S_SEAL);
   assign bus.alarm      = (r_state == S_ALARM);
   assign bus.alarm_code = r_code;
   assign bus.busy       = (r_state != S_IDLE) && (r_state != S_ALARM);
   assign bus.cork_ok    = (r_corks != 5'd0);
   assign bus.corks      = r_corks;
   assign bus.units      = r_units;
   assign bus.dozens     = r_dozens;
endmodule

// File: tb/tb_sequenciador_envase.sv
// Directed scoreboard bench for sequenciador_envase: full cycles, counter wrap,
// fill timeout, stop handling, cork exhaustion, seal fault and async reset.
module tb_sequenciador_envase;
   typedef struct {
      int corks;
      int units;
      int dozens;
   } exp_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   mCorks;
   int   mUnits;
   int   mDozens;
   int   valveCount;
   exp_t sbQ[$];

   sequenciador_envase_if bus();

   sequenciador_envase #(
      .FILL_TIMEOUT(15),
      .CORK_MAX(20),
      .CORK_LOAD(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int satCorks(input int v);
      return (v > 20) ? 20 : v;
   endfunction

   task automatic modelSeal();
      mCorks--;
      mUnits++;
      if (mUnits == 12) begin
         mUnits  = 0;
         mDozens = (mDozens + 1) % 100;
      end
   endtask

   task automatic pulseReload();
      bus.cork_reload = 1'b1;
      tick();
      bus.cork_reload = 1'b0;
      mCorks = satCorks(mCorks + 10);
      checkOutput("reload_corks", int'(bus.corks), mCorks);
   endtask

   task automatic startLine();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("start_motor", int'(bus.motor), 1);
   endtask

   // One bottle from MOVE_FILL through SEAL; the expected counters are queued
   // when seal_done is driven and retired after the edge that consumes it.
   task automatic runBottle(input int fillCycles, input bit stopInFill, input bit doReload);
      exp_t e;
      exp_t got;
      int   cont;
      int   vc;
      vc = 0;
      bus.pos_fill = 1'b1;
      tick();
      bus.pos_fill = 1'b0;
      if (bus.valve) vc++;
      for (int i = 1; i < fillCycles; i++) begin
         bus.stop = stopInFill && (i == 1);
         tick();
         bus.stop = 1'b0;
         if (bus.valve) vc++;
      end
      bus.level = 1'b1;
      tick();
      bus.level = 1'b0;
      checkOutput("valve_cycles", vc, fillCycles);
      checkOutput("move_seal_motor", int'(bus.motor), 1);
      checkOutput("move_seal_alarm", int'(bus.alarm), 0);
      bus.pos_seal    = 1'b1;
      bus.cork_reload = doReload;
      tick();
      bus.pos_seal    = 1'b0;
      bus.cork_reload = 1'b0;
      if (doReload) mCorks = satCorks(mCorks + 10);
      checkOutput("seal_req_high", int'(bus.seal_req), 1);
      bus.seal_done = 1'b1;
      modelSeal();
      e.corks  = mCorks;
      e.units  = mUnits;
      e.dozens = mDozens;
      sbQ.push_back(e);
      cont = (!stopInFill && mCorks > 0) ? 1 : 0;
      tick();
      bus.seal_done = 1'b0;
      if (sbQ.size() == 0) begin
         checkOutput("sb_empty", 1, 0);
      end else begin
         got = sbQ.pop_front();
         checkOutput("sb_corks", int'(bus.corks), got.corks);
         checkOutput("sb_units", int'(bus.units), got.units);
         checkOutput("sb_dozens", int'(bus.dozens), got.dozens);
      end
      checkOutput("seal_req_drop", int'(bus.seal_req), 0);
      checkOutput("after_seal_motor", int'(bus.motor), cont);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mCorks      = 0;
      mUnits      = 0;
      mDozens     = 0;
      bus.start = 0; bus.stop = 0; bus.pos_fill = 0; bus.level = 0;
      bus.pos_seal = 0; bus.seal_done = 0; bus.seal_alarm = 0;
      bus.cork_reload = 0; bus.ack = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) tick();
      checkOutput("rst_motor", int'(bus.motor), 0);
      checkOutput("rst_valve", int'(bus.valve), 0);
      checkOutput("rst_seal_req", int'(bus.seal_req), 0);
      checkOutput("rst_alarm", int'(bus.alarm), 0);
      checkOutput("rst_code", int'(bus.alarm_code), 0);
      checkOutput("rst_units", int'(bus.units), 0);
      checkOutput("rst_dozens", int'(bus.dozens), 0);
      checkOutput("rst_corks", int'(bus.corks), 0);
      checkOutput("rst_cork_ok", int'(bus.cork_ok), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      reset = 1'b1;
      tick();

      pulseReload();
      checkOutput("cork_ok_loaded", int'(bus.cork_ok), 1);
      startLine();
      checkOutput("busy_running", int'(bus.busy), 1);
      repeat (2) tick();
      checkOutput("wait_fill_motor", int'(bus.motor), 1);
      runBottle(4, 1'b0, 1'b0);
      checkOutput("first_corks", int'(bus.corks), 9);
      checkOutput("first_units", int'(bus.units), 1);

      for (int i = 0; i < 11; i++) runBottle(2, 1'b0, mCorks < 5);
      checkOutput("dozen_units", int'(bus.units), 0);
      checkOutput("dozen_dozens", int'(bus.dozens), 1);
      for (int i = 0; i < 1187; i++) runBottle(1, 1'b0, mCorks < 5);
      checkOutput("pre_wrap_units", int'(bus.units), 11);
      checkOutput("pre_wrap_dozens", int'(bus.dozens), 99);
      runBottle(1, 1'b0, mCorks < 5);
      checkOutput("wrap_units", int'(bus.units), 0);
      checkOutput("wrap_dozens", int'(bus.dozens), 0);

      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      checkOutput("stop_mf_busy", int'(bus.busy), 0);
      checkOutput("stop_mf_motor", int'(bus.motor), 0);
      checkOutput("stop_mf_units", int'(bus.units), mUnits);
      checkOutput("stop_mf_corks", int'(bus.corks), mCorks);

      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      checkOutput("start_stop_idle", int'(bus.busy), 0);

      startLine();
      runBottle(3, 1'b1, 1'b0);
      checkOutput("stop_fill_idle", int'(bus.busy), 0);

      startLine();
      bus.pos_fill = 1'b1;
      tick();
      bus.pos_fill = 1'b0;
      valveCount = 0;
      for (int i = 0; i < 40 && !bus.alarm; i++) begin
         if (bus.valve) valveCount++;
         tick();
      end
      checkOutput("timeout_valve_cycles", valveCount, 15);
      checkOutput("timeout_alarm", int'(bus.alarm), 1);
      checkOutput("timeout_code", int'(bus.alarm_code), 2);
      checkOutput("timeout_valve_off", int'(bus.valve), 0);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checkOutput("timeout_ack_alarm", int'(bus.alarm), 0);
      checkOutput("timeout_ack_code", int'(bus.alarm_code), 0);
      checkOutput("timeout_ack_busy", int'(bus.busy), 0);

      startLine();
      runBottle(15, 1'b0, 1'b0);

      for (int g = 0; g < 40 && mCorks > 1; g++) runBottle(1, 1'b0, 1'b0);
      runBottle(1, 1'b0, 1'b0);
      checkOutput("exhaust_busy", int'(bus.busy), 0);
      checkOutput("exhaust_cork_ok", int'(bus.cork_ok), 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("nocork_alarm", int'(bus.alarm), 1);
      checkOutput("nocork_code", int'(bus.alarm_code), 1);
      checkOutput("nocork_motor", int'(bus.motor), 0);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checkOutput("nocork_ack_hold", int'(bus.alarm), 1);
      pulseReload();
      checkOutput("nocork_reload_alarm", int'(bus.alarm), 1);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checkOutput("nocork_exit_alarm", int'(bus.alarm), 0);
      checkOutput("nocork_exit_code", int'(bus.alarm_code), 0);
      checkOutput("nocork_exit_corks", int'(bus.corks), 10);

      startLine();
      bus.pos_fill = 1'b1;
      tick();
      bus.pos_fill = 1'b0;
      bus.level = 1'b1;
      tick();
      bus.level = 1'b0;
      bus.pos_seal = 1'b1;
      tick();
      bus.pos_seal = 1'b0;
      checkOutput("fault_seal_req", int'(bus.seal_req), 1);
      bus.seal_alarm = 1'b1;
      bus.seal_done  = 1'b1;
      tick();
      bus.seal_alarm = 1'b0;
      bus.seal_done  = 1'b0;
      checkOutput("fault_alarm", int'(bus.alarm), 1);
      checkOutput("fault_code", int'(bus.alarm_code), 3);
      checkOutput("fault_seal_req_drop", int'(bus.seal_req), 0);
      checkOutput("fault_corks", int'(bus.corks), mCorks);
      checkOutput("fault_units", int'(bus.units), mUnits);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checkOutput("fault_ack_alarm", int'(bus.alarm), 0);

      startLine();
      bus.pos_fill = 1'b1;
      tick();
      bus.pos_fill = 1'b0;
      checkOutput("prereset_valve", int'(bus.valve), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_valve", int'(bus.valve), 0);
      checkOutput("async_motor", int'(bus.motor), 0);
      checkOutput("async_busy", int'(bus.busy), 0);
      checkOutput("async_corks", int'(bus.corks), 0);
      checkOutput("async_cork_ok", int'(bus.cork_ok), 0);
      checkOutput("async_units", int'(bus.units), 0);
      checkOutput("async_dozens", int'(bus.dozens), 0);
      checkOutput("async_code", int'(bus.alarm_code), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sequenciador_envase.md
# sequenciador_envase

Line sequencer for the automatic bottling line. It moves each bottle from the conveyor to the filling station, opens the fill valve until the level sensor trips, and moves the bottle on to the sealing station. It then hands the bottle to the sealing FSM through a request/done handshake. It also tracks the cork stock that feeds the sealer's cork input, counts sealed bottles in units and dozens, and raises a coded alarm on any line fault.

## Interface
- FILL_TIMEOUT, 15: maximum cycles the valve may stay open (≥2).
- CORK_MAX, 20: cork magazine capacity (≤31).
- CORK_LOAD, 10: corks added per reload pulse.
- clk  in  1  line clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears everything immediately).
- start  in  1  level; request to run the line.
- stop  in  1  level; request to stop after the current bottle.
- pos_fill  in  1  bottle present at the filling position.
- level  in  1  bottle full.
- pos_seal  in  1  bottle present at the sealing position.
- seal_done  in  1  sealing FSM finished (one-cycle pulse).
- seal_alarm  in  1  sealing FSM fault.
- cork_reload  in  1  one-cycle pulse; operator loaded corks.
- ack  in  1  operator alarm acknowledge.
- motor  out  1  conveyor motor on.
- valve  out  1  fill valve open.
- seal_req  out  1  request to the sealing FSM.
- cork_ok  out  1  cork stock nonzero; drives the sealer's cork input.
- corks  out  5  current cork stock.
- units  out  4  sealed bottles mod 12.
- dozens  out  7  completed dozens mod 100.
- alarm  out  1  line in alarm.
- alarm_code  out  2  00 none, 01 no cork, 10 fill timeout, 11 seal fault.
- busy  out  1  state is not IDLE and not ALARM.

## Operation
- Moore FSM with states IDLE, MOVE_FILL, FILL, MOVE_SEAL, SEAL, ALARM. All outputs are decoded from registered state and counters only.
- Output decode by state:
  - motor=1 in MOVE_FILL and MOVE_SEAL.
  - valve=1 in FILL.
  - seal_req=1 in SEAL.
  - alarm=1 in ALARM.
  - All actuators are 0 in IDLE and ALARM.
- A `run` flag is set when the FSM leaves IDLE. It is cleared by stop=1 in any cycle and by entry to IDLE or ALARM.
- IDLE transitions:
  - stop=1: stay in IDLE (stop beats start).
  - Else start=1 with corks=0: go to ALARM, code 01.
  - Else start=1: go to MOVE_FILL.
- MOVE_FILL transitions:
  - run=0 or stop=1: go to IDLE (no bottle has been committed yet).
  - Else pos_fill=1: go to FILL.
- FILL transitions:
  - level=1: go to MOVE_SEAL.
  - Else the fill timer reaches FILL_TIMEOUT-1: go to ALARM, code 10.
  - stop is ignored; the bottle is always finished.
- MOVE_SEAL transitions: pos_seal=1 goes to SEAL.
- SEAL transitions (seal_alarm has priority):
  - seal_alarm=1: go to ALARM, code 11; no counters change.
  - Else seal_done=1: decrement corks and increment the bottle count. Then go to MOVE_FILL if run=1, stop=0 and the post-decrement corks > 0; otherwise go to IDLE.
- ALARM transitions: ack=1 goes to IDLE, except with code 01, which also requires corks>0. alarm_code returns to 00 on exit.
- Cork counter:
  - The next value is computed as corks − dec + (cork_reload ? CORK_LOAD : 0), saturating at CORK_MAX.
  - Decrement and reload in the same cycle both apply.
  - The counter never underflows; a decrement at 0 cannot occur because SEAL is only entered with corks>0.
- Bottle count: units increments; on 11→0 it wraps and dozens increments. dozens wraps 99→0.

## Timing
- Reset values:
  - state = IDLE, run=0.
  - motor, valve, seal_req, alarm = 0; alarm_code=00.
  - units=0, dozens=0, corks=0, so cork_ok=0.
  - Reset is asynchronous and wins over any in-progress state, including an open valve.
- Sensor latency: an input sampled high at edge k changes state at edge k; the new outputs are valid after edge k.
- Fill timer:
  - Cleared on entry to FILL and incremented each cycle spent in FILL.
  - The valve is open at most FILL_TIMEOUT cycles.
  - If level=1 arrives on the timeout edge, level wins and the FSM goes to MOVE_SEAL.
- Handshake:
  - seal_req is held high until seal_done or seal_alarm.
  - seal_req drops in the cycle after the done/alarm edge.
  - Only one bottle is in flight at a time.
- Counters update on the same edge as the SEAL exit.

## Test plan
- Full cycle: reset, cork_reload → corks=10; start=1; pos_fill at cycle 3; level 4 cycles later; pos_seal; seal_done. Expect valve high exactly 4 cycles, corks=9, units=1, FSM back in MOVE_FILL.
- Dozens wrap: 12 consecutive bottles with 2 reloads → units=0, dozens=1. Then preload 1199 bottles' worth of count: the next bottle gives dozens=0, units=0.
- Fill timeout: level held at 0 → valve high exactly 15 cycles, then alarm=1, code 10. ack → IDLE. A repeat run where level=1 arrives on cycle 15 → MOVE_SEAL, no alarm.
- Stop handling:
  - stop during FILL → bottle still sealed, then IDLE.
  - stop during MOVE_FILL → IDLE the next cycle, counters unchanged.
  - start=stop=1 in IDLE → stays in IDLE.
- Cork exhaustion: corks=1; seal completes → IDLE, cork_ok=0. start → ALARM code 01. ack alone → stays in ALARM. cork_reload then ack → IDLE with corks=10.
- Seal fault and reset: seal_alarm together with seal_done → ALARM code 11, counters unchanged. Separately, reset=0 mid-FILL → valve=0 immediately, all outputs at reset values.
